noc_mapper_receiver: RTL and testbench

//  Mapper-side endpoint of the SRAM->NoC input path. Accepts flits addressed to its port, buffers them
//  in a credit-protected FIFO, presents them to the mapper over valid/ready, and returns one credit per

---
 rtl/noc_mapper_receiver_pkg.sv | 29 ++
 rtl/noc_mapper_receiver_rx_fifo.sv | 52 +++++
 rtl/noc_mapper_receiver.sv | 132 +++++++++++++
 tb/tb_noc_mapper_receiver.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_mapper_receiver_pkg.sv
// Shared definitions for the mapper-side NoC receiver: flit field layout and packet-state encoding.
// Flit layout is {valid, tail, dest, vc, data}, MSB first, matching the input controller's packing.
package noc_mapper_receiver_pkg;

    typedef enum logic {
        PKT_IDLE = 1'b0,
        PKT_IN   = 1'b1
    } pkt_state_e;

    localparam int FLIT_CTRL_BITS = 2;

    function automatic int flit_width(input int data_w, input int dest_w, input int vc_w);
        return FLIT_CTRL_BITS + data_w + dest_w + vc_w;
    endfunction

    function automatic int flit_valid_bit(input int fw);
        return fw - 1;
    endfunction

    function automatic int flit_tail_bit(input int fw);
        return fw - 2;
    endfunction

    // Occupancy/credit counters must hold the value DEPTH itself.
    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/noc_mapper_receiver_rx_fifo.sv
// First-word-fall-through FIFO: head is visible the cycle after a push into an empty FIFO.
// The caller gates push on !full || pop; a push+pop on a full FIFO writes into the slot being freed.
module noc_rx_fifo
    import noc_mapper_receiver_pkg::*;
#(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = cnt_bits(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/noc_mapper_receiver.sv
// Mapper-side NoC endpoint: decodes flits for MY_PORT into a FWFT FIFO (1-cycle latency) and returns one
// credit per popped flit; backpressure is data_ready, credits accumulate while en_credit_out is low.
module noc_mapper_receiver
    import noc_mapper_receiver_pkg::*;
#(
    parameter  int FLIT_DATA_WIDTH = 32,
    parameter  int DEST_BITS       = 2,
    parameter  int VC_BITS         = 1,
    parameter  int MY_PORT         = 1,
    parameter  int DEPTH           = 8,
    localparam int FW              = flit_width(FLIT_DATA_WIDTH, DEST_BITS, VC_BITS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [FW-1:0]              flit_in,
    input  logic                       en_credit_out,
    output logic [VC_BITS:0]           credit_out,
    output logic [FLIT_DATA_WIDTH-1:0] data_out,
    output logic                       data_valid,
    output logic                       data_sop,
    output logic                       data_tail,
    input  logic                       data_ready,
    output logic [15:0]                packet_count,
    output logic                       err_misroute,
    output logic                       err_overflow
);

    localparam int VLD_IDX  = flit_valid_bit(FW);
    localparam int TAIL_IDX = flit_tail_bit(FW);
    localparam int CW       = cnt_bits(DEPTH);

    logic                       flit_vld;
    logic                       flit_tail;
    logic [DEST_BITS-1:0]       flit_dest;
    logic [VC_BITS-1:0]         flit_vc;
    logic [FLIT_DATA_WIDTH-1:0] flit_dat;
    logic                       dest_ok;

    assign flit_vld  = flit_in[VLD_IDX];
    assign flit_tail = flit_in[TAIL_IDX];
    assign flit_dest = flit_in[FW-3 -: DEST_BITS];
    assign flit_vc   = flit_in[FLIT_DATA_WIDTH +: VC_BITS];
    assign flit_dat  = flit_in[FLIT_DATA_WIDTH-1:0];
    assign dest_ok   = (flit_dest == DEST_BITS'(MY_PORT));

    logic                     push;
    logic                     pop;
    logic                     full;
    logic                     empty;
    logic [FLIT_DATA_WIDTH:0] head;
    logic [CW-1:0]            fifo_count;
    logic                     head_tail;

    assign pop       = ~empty & data_ready;
    assign push      = flit_vld & dest_ok & (~full | pop);
    assign head_tail = head[FLIT_DATA_WIDTH];

    noc_rx_fifo #(
        .WIDTH (FLIT_DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat ({flit_tail, flit_dat}),
        .pop      (pop),
        .pop_dat  (head),
        .count    (fifo_count),
        .full     (full),
        .empty    (empty)
    );

    // Memory is not reset, so the head is masked while the FIFO is empty.
    assign data_valid = ~empty;
    assign data_out   = empty ? '0 : head[FLIT_DATA_WIDTH-1:0];
    assign data_tail  = ~empty & head_tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_misroute <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_misroute <= flit_vld & ~dest_ok;
            if (flit_vld & dest_ok & full & ~pop) begin
                err_overflow <= 1'b1;
            end
        end
    end

    logic [CW-1:0] pend_q;
    logic          sent;

    // A pop can be returned in the same cycle it happens, bypassing the pending counter.
    assign sent = en_credit_out & ((pend_q != '0) | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            credit_out <= '0;
        end else begin
            pend_q     <= pend_q + CW'(pop) - CW'(sent);
            credit_out <= {sent, {VC_BITS{1'b0}}};
        end
    end

    pkt_state_e state_q;
    pkt_state_e state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PKT_IDLE;
            packet_count <= '0;
        end else begin
            state_q <= state_d;
            if (pop & head_tail) begin
                packet_count <= packet_count + 16'd1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        data_sop = (state_q == PKT_IDLE);
        if (pop) begin
            state_d = head_tail ? PKT_IDLE : PKT_IN;
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, flit_vc, fifo_count};

endmodule

// File: tb/tb_noc_mapper_receiver.sv
// Randomized and directed bench for noc_mapper_receiver against a queue-based packet/credit model.
module tb_noc_mapper_receiver;

    localparam int DW    = 8;
    localparam int DB    = 2;
    localparam int VB    = 1;
    localparam int MY    = 1;
    localparam int DEPTH = 8;
    localparam int FW    = 2 + DW + DB + VB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [FW-1:0] flit_in = '0;
    logic          en_credit_out = 1'b0;
    logic [VB:0]   credit_out;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_sop;
    logic          data_tail;
    logic          data_ready = 1'b0;
    logic [15:0]   packet_count;
    logic          err_misroute;
    logic          err_overflow;

    always #5 clk = ~clk;

    noc_mapper_receiver #(
        .FLIT_DATA_WIDTH (DW),
        .DEST_BITS       (DB),
        .VC_BITS         (VB),
        .MY_PORT         (MY),
        .DEPTH           (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flit_in       (flit_in),
        .en_credit_out (en_credit_out),
        .credit_out    (credit_out),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .data_sop      (data_sop),
        .data_tail     (data_tail),
        .data_ready    (data_ready),
        .packet_count  (packet_count),
        .err_misroute  (err_misroute),
        .err_overflow  (err_overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: buffered flits as {tail,data}, plus packet/credit/error bookkeeping.
    logic [DW:0] q[$];
    int  m_pend;
    int  m_pkts;
    bit  m_in_pkt;
    bit  m_ovf;
    bit  m_mis;
    bit  m_cred;
    int  credits_seen;
    int  pops_since;

    task automatic model_reset();
        q.delete();
        m_pend       = 0;
        m_pkts       = 0;
        m_in_pkt     = 0;
        m_ovf        = 0;
        m_mis        = 0;
        m_cred       = 0;
        credits_seen = 0;
        pops_since   = 0;
    endtask

    task automatic compare_all();
        check("data_valid", 32'(data_valid), 32'(q.size() > 0));
        check("data_out", 32'(data_out), (q.size() > 0) ? 32'(q[0][DW-1:0]) : 32'd0);
        check("data_sop", 32'(data_sop), 32'(!m_in_pkt));
        check("data_tail", 32'(data_tail), (q.size() > 0) ? 32'(q[0][DW]) : 32'd0);
        check("credit_out", 32'(credit_out), 32'({m_cred, 1'b0}));
        check("packet_count", 32'(packet_count), 32'(m_pkts));
        check("err_misroute", 32'(err_misroute), 32'(m_mis));
        check("err_overflow", 32'(err_overflow), 32'(m_ovf));
        if (credit_out[VB]) credits_seen++;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare away from the edge.
    task automatic step(input bit v, input bit t, input logic [DB-1:0] d,
                        input logic [DW-1:0] dat, input bit rdy, input bit en);
        bit          pop;
        bit          mine;
        int          sz;
        logic [DW:0] head;
        flit_in       = {v, t, d, 1'b0, dat};
        data_ready    = rdy;
        en_credit_out = en;
        @(posedge clk);
        sz   = q.size();
        pop  = (sz > 0) && rdy;
        mine = v && (d == DB'(MY));
        m_mis = v && !mine;
        if (mine && sz == DEPTH && !pop) m_ovf = 1;
        if (pop) begin
            head = q.pop_front();
            pops_since++;
            if (head[DW]) begin
                m_pkts   = (m_pkts + 1) % 65536;
                m_in_pkt = 0;
            end else begin
                m_in_pkt = 1;
            end
        end
        if (mine && (sz < DEPTH || pop)) q.push_back({t, dat});
        m_cred = en && (m_pend > 0 || pop);
        m_pend = m_pend + int'(pop) - int'(m_cred);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input bit rdy, input bit en);
        step(1'b0, 1'b0, '0, '0, rdy, en);
    endtask

    // Called at a falling edge; asserts reset mid-phase and checks outputs before any clock edge.
    task automatic do_reset();
        flit_in = '0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int c0;
    int rdy_pct;

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Single three-flit packet
        c0 = credits_seen;
        step(1, 0, DB'(MY), 8'hA1, 1, 1);
        check("t2_first_data", 32'(data_out), 32'hA1);
        check("t2_first_sop", 32'(data_sop), 32'd1);
        step(1, 0, DB'(MY), 8'hA2, 1, 1);
        step(1, 1, DB'(MY), 8'hA3, 1, 1);
        check("t2_tail", 32'(data_tail), 32'd1);
        repeat (3) idle(1, 1);
        check("t2_credits", 32'(credits_seen - c0), 32'd3);
        check("t2_pkts", 32'(packet_count), 32'd1);

        // Backpressure to full, then overflow
        c0 = credits_seen;
        for (int i = 0; i < DEPTH; i++) step(1, (i == DEPTH - 1), DB'(MY), 8'(8'h30 + i), 0, 1);
        check("t3_no_credit", 32'(credits_seen - c0), 32'd0);
        step(1, 1, DB'(MY), 8'h99, 0, 1);
        check("t3_overflow", 32'(err_overflow), 32'd1);
        check("t3_head", 32'(data_out), 32'h30);
        repeat (10) idle(1, 1);
        check("t3_credits", 32'(credits_seen - c0), 32'd8);
        check("t3_pkts", 32'(packet_count), 32'd2);

        // Credit hold then release
        c0 = credits_seen;
        for (int i = 0; i < 5; i++) step(1, (i == 4), DB'(MY), 8'(8'h50 + i), 1, 0);
        repeat (3) idle(1, 0);
        check("t4_held", 32'(credits_seen - c0), 32'd0);
        repeat (8) idle(1, 1);
        check("t4_released", 32'(credits_seen - c0), 32'd5);
        check("t4_quiet", 32'(credit_out), 32'd0);

        // Misroute
        c0 = credits_seen;
        step(1, 0, DB'(MY ^ 1), 8'h55, 1, 1);
        check("t5_misroute", 32'(err_misroute), 32'd1);
        check("t5_fifo_empty", 32'(data_valid), 32'd0);
        idle(1, 1);
        check("t5_misroute_clear", 32'(err_misroute), 32'd0);
        check("t5_no_credit", 32'(credits_seen - c0), 32'd0);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, (i == DEPTH - 1), DB'(MY), 8'(8'h60 + i), 0, 1);
        step(1, 1, DB'(MY), 8'hEE, 1, 1);
        check("t6_no_overflow", 32'(err_overflow), 32'd0);
        repeat (DEPTH - 1) idle(1, 1);
        check("t6_last_data", 32'(data_out), 32'hEE);
        check("t6_last_sop", 32'(data_sop), 32'd1);
        idle(1, 1);
        check("t6_pkts", 32'(packet_count), 32'd2);
        check("t6_sop_idle", 32'(data_sop), 32'd1);

        // Randomized traffic with varying drain rate and occasional reset
        rdy_pct = 60;
        for (int n = 0; n < 3000; n++) begin
            logic [DB-1:0] d;
            if (n % 256 == 0) begin
                case ($urandom % 3)
                    0:       rdy_pct = 15;
                    1:       rdy_pct = 60;
                    default: rdy_pct = 95;
                endcase
            end
            if ($urandom % 700 == 0) do_reset();
            d = ($urandom % 8 == 0) ? DB'($urandom) : DB'(MY);
            step(($urandom % 4) != 0, ($urandom % 4) == 0, d, DW'($urandom),
                 ($urandom % 100) < rdy_pct, ($urandom % 4) != 0);
        end
        repeat (40) idle(1, 1);
        check("credit_total", 32'(credits_seen), 32'(pops_since));
        check("drained", 32'(data_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
